// File: rtl/vec_adder.sv
// vec_adder: memory-to-memory vector adder; reads two operand vectors from mem and writes their sums back.
module vec_adder #(
  parameter int DATA_W = 8,
  parameter int MEM_W  = 32,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_a,
  input  logic [ADDR_W-1:0] src_b,
  input  logic [ADDR_W-1:0] dst,
  input  logic [ADDR_W-1:0] len,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] count,
  output logic [DATA_W-1:0] last_sum
);
  localparam logic [1:0] IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2, DONE = 2'd3;
  logic [1:0] state;
  logic [ADDR_W-1:0] a, b, d, n, i, ra, rb, wa;
  logic [DATA_W-1:0] op_a, op_b, sum;
  logic [MEM_W-1:0] mem [DEPTH-1:0];
  // address sums are ADDR_W wide so base+i wraps modulo DEPTH
  assign ra = a + i;
  assign rb = b + i;
  assign wa = d + i;
  assign sum = op_a + op_b;
  assign busy = state == READ || state == WRITE;
  assign done = state == DONE;
  always_ff @(posedge clock)
    if (reset) begin
      state <= IDLE;
      i <= '0;
      count <= '0;
      last_sum <= '0;
    end else
      case (state)
        IDLE: if (start) begin
          a <= src_a;
          b <= src_b;
          d <= dst;
          n <= len;
          i <= '0;
          count <= '0;
          state <= len == '0 ? DONE : READ;
        end
        READ: begin
          op_a <= mem[ra][DATA_W-1:0];
          op_b <= mem[rb][DATA_W-1:0];
          state <= WRITE;
        end
        WRITE: begin
          last_sum <= sum;
          count <= count + 1'b1;
          i <= i + 1'b1;
          state <= i + 1'b1 == n ? DONE : READ;
        end
        default: state <= IDLE;
      endcase
  // a reset arriving on a WRITE edge suppresses that write
  always_ff @(posedge clock)
    if (!reset && state == WRITE) mem[wa] <= {{(MEM_W-DATA_W){1'b0}}, sum};
endmodule

// File: tb/tb_vec_adder.sv
// tb_vec_adder: random and directed jobs checked every cycle against a behavioural job model.
module tb_vec_adder;
  logic clock = 0, reset = 1, start = 0;
  logic [7:0] src_a = 0, src_b = 0, dst = 0, len = 0;
  logic busy, done;
  logic [7:0] count, last_sum;
  vec_adder dut (.clock(clock), .reset(reset), .start(start), .src_a(src_a), .src_b(src_b),
                 .dst(dst), .len(len), .busy(busy), .done(done), .count(count), .last_sum(last_sum));
  always #5 clock = ~clock;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;
  int n_cmp = 0, n_bad = 0;
  logic [31:0] model [256];
  int job_a = -1000, job_n = 0, done_d = -1;
  logic [7:0] sums [$];
  logic [7:0] prev_last = 0;
  bit go = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // expectations derived from the job timeline: cycle d after acceptance
  always @(negedge clock) if (go) begin
    int d, ec;
    logic [7:0] el;
    d = cyc - job_a + 1;
    ec = d <= 2 ? 0 : ((d - 1) / 2 > job_n ? job_n : (d - 1) / 2);
    el = ec > 0 ? sums[ec-1] : prev_last;
    chk("busy", {31'd0, busy}, {31'd0, d >= 1 && d <= 2 * job_n});
    chk("done", {31'd0, done}, {31'd0, d == 2 * job_n + 1});
    chk("count", {24'd0, count}, ec);
    chk("last_sum", {24'd0, last_sum}, {24'd0, el});
    if (done) done_d = d;
  end

  task automatic poke(input logic [7:0] ad, input logic [31:0] v);
    dut.mem[ad] = v;
    model[ad] = v;
  endtask

  task automatic memcheck(input string name);
    int errs = 0;
    for (int k = 0; k < 256; k++) if (dut.mem[k] !== model[k]) errs++;
    chk(name, errs, 0);
  endtask

  task automatic accept(input logic [7:0] sa, sb, ds, n, input int upto);
    @(posedge clock); #1;
    src_a = sa; src_b = sb; dst = ds; len = n; start = 1;
    @(posedge clock); #1;
    start = 0;
    if (job_n > 0) prev_last = sums[job_n-1];
    sums.delete();
    for (int k = 0; k < upto; k++) begin
      logic [7:0] s;
      s = model[8'(sa + k)][7:0] + model[8'(sb + k)][7:0];
      model[8'(ds + k)] = {24'd0, s};
      sums.push_back(s);
    end
    job_n = n;
    job_a = cyc;
    src_a = 8'($urandom); src_b = 8'($urandom); dst = 8'($urandom); len = 8'($urandom);
  endtask

  task automatic run(input logic [7:0] sa, sb, ds, n, input bit extra);
    done_d = -1;
    accept(sa, sb, ds, n, n);
    if (extra && n > 0) begin
      @(posedge clock); #1 start = 1;
      @(posedge clock); #1 start = 0;
    end
    repeat (2 * n + 3) @(posedge clock);
    #1;
    memcheck("mem_all");
  endtask

  initial begin
    for (int k = 0; k < 256; k++) poke(8'(k), $urandom);
    repeat (3) @(posedge clock);
    #1 reset = 0;
    go = 1;
    // basic sum
    for (int k = 0; k < 4; k++) begin
      poke(8'(k), k + 1);
      poke(8'(16 + k), 10 * (k + 1));
    end
    run(0, 16, 32, 4, 0);
    chk("basic_m32", dut.mem[32], 11);
    chk("basic_m35", dut.mem[35], 44);
    chk("basic_done_d", done_d, 9);
    chk("basic_count", {24'd0, count}, 4);
    chk("basic_last", {24'd0, last_sum}, 44);
    // overflow
    poke(0, 32'hFF); poke(1, 32'h02);
    run(0, 1, 2, 1, 0);
    chk("ovf_m2", dut.mem[2], 32'h1);
    chk("ovf_last", {24'd0, last_sum}, 1);
    // wrap and upper bits
    poke(254, 5); poke(255, 5); poke(0, 32'hABCD0005); poke(1, 5);
    for (int k = 0; k < 4; k++) poke(8'(100 + k), 1);
    run(254, 100, 200, 4, 0);
    for (int k = 0; k < 4; k++) chk("wrap_res", dut.mem[200 + k], 6);
    chk("wrap_m0", dut.mem[0], 32'hABCD0005);
    // in place then empty job
    poke(8, 3); poke(9, 7);
    run(8, 9, 8, 1, 0);
    chk("inplace_m8", dut.mem[8], 10);
    run(8, 9, 8, 0, 0);
    chk("len0_done_d", done_d, 1);
    chk("len0_m8", dut.mem[8], 10);
    // start pulsed during WRITE is ignored
    run(8'($urandom), 8'($urandom), 8'($urandom), 3, 1);
    chk("extra_count", {24'd0, count}, 3);
    for (int j = 0; j < 12; j++)
      run(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom_range(0, 20)), j[0]);
    // reset during element 2 of a len=5 job
    for (int k = 0; k < 5; k++) begin
      poke(8'(40 + k), k + 1);
      poke(8'(60 + k), 10);
      poke(8'(80 + k), 32'h11111111);
    end
    accept(40, 60, 80, 5, 2);
    repeat (4) @(posedge clock);
    #1 reset = 1;
    @(posedge clock); #1;
    reset = 0;
    job_a = -1000; job_n = 0; prev_last = 0; sums.delete();
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_count", {24'd0, count}, 0);
    chk("rst_m80", dut.mem[80], 11);
    chk("rst_m81", dut.mem[81], 12);
    chk("rst_m82", dut.mem[82], 32'h11111111);
    chk("rst_m84", dut.mem[84], 32'h11111111);
    repeat (4) @(posedge clock);
    #1 memcheck("rst_mem_all");
    go = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
